instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream fetch stage of the multicycle CPU. It owns the program counter and issues word reads to instruction memory over a req/ack handshake. It presents the fetched word on Instruction with a one-cycle IRWrite strobe, which is consumed directly by the InstructionRegister. It supports a stall from the control FSM and a PC redirect for branches and jumps.

Parameters:
ADDR_W, 32, width of PC and memory address
PC_STEP, 4, PC increment per fetched instruction (bytes)
RESET_PC, 0, PC value after reset
TIMEOUT_CYCLES, 16, max REQ cycles without Mem_Ack (used only with FETCH_TIMEOUT_EN)

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  reset, asynchronous, active-low
Fetch_En  in  1  control FSM requests the next instruction
Stall  in  1  downstream not ready; hold the delivered instruction
Redirect  in  1  load PC from Redirect_Addr (branch/jump)
Redirect_Addr  in  ADDR_W  redirect target; bits [1:0] forced to 0
Mem_Req  out  1  memory read request
Mem_Addr  out  ADDR_W  memory read address, word-aligned
Mem_Ack  in  1  memory read data valid this cycle
Mem_Rdata  in  32  memory read data
Instruction  out  32  fetched instruction word, feeds InstructionRegister.Instruction
IRWrite  out  1  one-cycle load strobe, feeds InstructionRegister.IRWrite
PC  out  ADDR_W  address of the next instruction to fetch
Busy  out  1  high when not in IDLE
Fault  out  1  sticky fetch timeout flag (0 unless FETCH_TIMEOUT_EN)

Behaviour:
- Reset (Rst_n=0, async): state=IDLE, PC=RESET_PC, Mem_Addr=0, Mem_Req=0, Instruction=0, IRWrite=0, Busy=0, Fault=0, pending redirect cleared. A mid-transaction reset abandons the fetch; a late Mem_Ack is ignored.
- State machine: IDLE, REQ, DELIVER. Mem_Req=(state==REQ). Busy=(state!=IDLE).
- IDLE:
  - Redirect=1: PC<=aligned Redirect_Addr.
  - Fetch_En=1: Mem_Addr<=(Redirect ? aligned Redirect_Addr : PC), then go to REQ. Redirect and Fetch_En together fetch from the target.
- REQ: Mem_Addr is held stable and Mem_Req stays 1 until Mem_Ack.
  - Redirect in REQ does not abort the bus cycle. It is latched as pending (the last target wins).
  - On Mem_Ack with no pending redirect: Instruction<=Mem_Rdata, PC<=Mem_Addr+PC_STEP (mod 2^ADDR_W, wraps silently), go to DELIVER.
  - On Mem_Ack with a pending redirect: discard the data, PC<=pending target, clear pending, go to IDLE.
  - Mem_Ack in IDLE or DELIVER is ignored.
- DELIVER: IRWrite=(state==DELIVER)&&!Stall&&!Redirect. This is a combinational output; the IR samples it on the next rising edge.
  - Stall=1: stay in DELIVER; Instruction is held; IRWrite=0.
  - Redirect=1: squash. IRWrite=0, PC<=aligned Redirect_Addr, go to IDLE.
  - Otherwise: IRWrite=1 for exactly one cycle, then go to IDLE.
- Latency: Fetch_En sampled at edge N makes Mem_Req high from N. Mem_Ack sampled at edge M makes IRWrite high during cycle M..M+1 if not stalled. Minimum Fetch_En-to-IRWrite is 2 cycles with a zero-wait ack.
- Fetch_En is ignored outside IDLE. Back-to-back fetches need one IDLE cycle.

Optional Feature:
FETCH_TIMEOUT_EN.
- Defined: a cycle counter clears on entry to REQ. If TIMEOUT_CYCLES cycles pass in REQ without Mem_Ack, then Fault<=1 (sticky until reset), Mem_Req drops, state goes to IDLE, and PC is unchanged. A pending redirect is applied to PC on timeout.
- Undefined: no counter; REQ waits indefinitely; Fault is tied to 0.

Test Plan:
1. Reset release, Fetch_En pulse, Mem_Ack next cycle with Mem_Rdata=32'h8C220004 -> Mem_Addr=0, IRWrite one cycle, Instruction=32'h8C220004, PC=4, IR Opcode=6'h23.
2. Mem_Ack delayed 5 cycles -> Mem_Req high for 6 consecutive cycles, Mem_Addr stable at 0; PC=4 only after the ack.
3. Stall held 3 cycles in DELIVER -> IRWrite=0 for 3 cycles, then exactly one IRWrite pulse; Instruction unchanged throughout.
4. Redirect=1 with Redirect_Addr=32'h0000_0103 while in REQ, ack arrives -> data discarded, no IRWrite, PC=32'h0000_0100; the next fetch uses Mem_Addr=32'h100.
5. PC=32'hFFFF_FFFC, fetch and ack -> PC wraps to 0; Rst_n dropped mid-REQ -> all outputs return to reset values asynchronously.
6. FETCH_TIMEOUT_EN defined, no Mem_Ack -> after 16 REQ cycles Fault=1 and Mem_Req=0. Undefined -> Mem_Req stays 1 and Fault=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the multicycle CPU.
// Owns the PC, reads instruction words over a req/ack bus and hands each word
// to the InstructionRegister with a single-cycle IRWrite strobe.
// Optional build macro: FETCH_TIMEOUT_EN adds a REQ watchdog and a sticky Fault flag.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W         = 32,
    parameter int unsigned       PC_STEP        = 4,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Fetch_En,
    input  logic              Stall,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] Redirect_Addr,
    output logic              Mem_Req,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic              Mem_Ack,
    input  logic [31:0]       Mem_Rdata,
    output logic [31:0]       Instruction,
    output logic              IRWrite,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Fault
);

    typedef enum logic [1:0] {StIdle, StReq, StDeliver} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       instr_q, instr_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] redir_aligned;

    assign redir_aligned = {Redirect_Addr[ADDR_W-1:2], 2'b00};

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmr_q, tmr_d;
    logic          fault_q, fault_d;

    // Timer runs only while in REQ, so it is zero on every entry to REQ.
    always_comb begin
        tmr_d = '0;
        if (state_q == StReq) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // Watchdog timer and sticky fault flag.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tmr_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            tmr_q   <= tmr_d;
            fault_q <= fault_d;
        end
    end

    assign Fault = fault_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign Fault = 1'b0;
`endif

    // Next-state logic for the fetch FSM and its datapath registers.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        mem_addr_d  = mem_addr_q;
        instr_d     = instr_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
`ifdef FETCH_TIMEOUT_EN
        fault_d     = fault_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (Redirect) begin
                    pc_d = redir_aligned;
                end
                if (Fetch_En) begin
                    // A simultaneous redirect means fetch from the branch target.
                    mem_addr_d = Redirect ? redir_aligned : pc_q;
                    state_d    = StReq;
                end
            end
            StReq: begin
                // The bus cycle cannot be aborted; remember the redirect instead.
                if (Redirect) begin
                    pend_d      = 1'b1;
                    pend_addr_d = redir_aligned;
                end
                if (Mem_Ack) begin
                    if (pend_d) begin
                        pc_d    = pend_addr_d;
                        pend_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        instr_d = Mem_Rdata;
                        pc_d    = mem_addr_q + ADDR_W'(PC_STEP);
                        state_d = StDeliver;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmr_q == TmrLast) begin
                    fault_d = 1'b1;
                    if (pend_d) begin
                        pc_d = pend_addr_d;
                    end
                    pend_d  = 1'b0;
                    state_d = StIdle;
                end
`endif
            end
            StDeliver: begin
                // A redirect squashes the delivered word even while stalled.
                if (Redirect) begin
                    pc_d    = redir_aligned;
                    state_d = StIdle;
                end else if (!Stall) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            mem_addr_q  <= '0;
            instr_q     <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mem_addr_q  <= mem_addr_d;
            instr_q     <= instr_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    // Output decode; IRWrite is combinational so the IR loads on the next edge.
    always_comb begin
        Mem_Req     = (state_q == StReq);
        Busy        = (state_q != StIdle);
        IRWrite     = (state_q == StDeliver) && !Stall && !Redirect;
        Mem_Addr    = mem_addr_q;
        Instruction = instr_q;
        PC          = pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with an instruction-word scoreboard.
module tb_instr_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b0;
    logic        Fetch_En = 1'b0;
    logic        Stall = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] Redirect_Addr = '0;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_Rdata = '0;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic [31:0] Instruction;
    logic        IRWrite;
    logic [31:0] PC;
    logic        Busy;
    logic        Fault;

    int          vectors = 0;
    int          miscompares = 0;
    int          reqcnt;
    logic [31:0] exp_q[$];
    logic [31:0] discard;

    instr_fetch_unit #(
        .ADDR_W(32),
        .PC_STEP(4),
        .RESET_PC(32'h0),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .Fetch_En(Fetch_En),
        .Stall(Stall),
        .Redirect(Redirect),
        .Redirect_Addr(Redirect_Addr),
        .Mem_Req(Mem_Req),
        .Mem_Addr(Mem_Addr),
        .Mem_Ack(Mem_Ack),
        .Mem_Rdata(Mem_Rdata),
        .Instruction(Instruction),
        .IRWrite(IRWrite),
        .PC(PC),
        .Busy(Busy),
        .Fault(Fault)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Check IRWrite; on a strobe the delivered word must match the scoreboard head.
    task automatic check_ir(input string tag, input logic exp_wr);
        chk({tag, "_irwrite"}, 32'(IRWrite), 32'(exp_wr));
        if (IRWrite && exp_wr) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
            end else begin
                chk({tag, "_instr"}, Instruction, exp_q.pop_front());
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_req"}, 32'(Mem_Req), 32'd0);
        chk({tag, "_addr"}, Mem_Addr, 32'h0);
        chk({tag, "_instr"}, Instruction, 32'h0);
        chk({tag, "_irwrite"}, 32'(IRWrite), 32'd0);
        chk({tag, "_pc"}, PC, 32'h0);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_fault"}, 32'(Fault), 32'd0);
    endtask

    task automatic start_fetch();
        Fetch_En = 1'b1;
        tick();
        Fetch_En = 1'b0;
    endtask

    // Acknowledge with data that is expected to reach the IR.
    task automatic push_ack(input logic [31:0] data);
        Mem_Ack   = 1'b1;
        Mem_Rdata = data;
        exp_q.push_back(data);
        tick();
        Mem_Ack = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_reset("rst");
        Rst_n = 1'b1;
        tick();

        // 1: zero-wait fetch
        start_fetch();
        chk("t1_req", 32'(Mem_Req), 32'd1);
        chk("t1_addr", Mem_Addr, 32'h0);
        chk("t1_busy", 32'(Busy), 32'd1);
        chk("t1_pc_before", PC, 32'h0);
        push_ack(32'h8C22_0004);
        chk("t1_opcode", 32'(Instruction[31:26]), 32'h23);
        chk("t1_pc", PC, 32'h4);
        check_ir("t1", 1'b1);
        tick();
        check_ir("t1_after", 1'b0);
        chk("t1_idle", 32'(Busy), 32'd0);

        // 2: ack delayed five cycles, after an async reset back to PC 0
        Rst_n = 1'b0;
        #1;
        chk("t2_rst_pc", PC, 32'h0);
        Rst_n = 1'b1;
        tick();
        reqcnt = 0;
        start_fetch();
        for (int i = 0; i < 5; i++) begin
            if (Mem_Req) reqcnt++;
            chk("t2_addr_hold", Mem_Addr, 32'h0);
            chk("t2_pc_hold", PC, 32'h0);
            tick();
        end
        if (Mem_Req) reqcnt++;
        push_ack(32'hCAFE_0001);
        chk("t2_req_cycles", 32'(reqcnt), 32'd6);
        chk("t2_req_drop", 32'(Mem_Req), 32'd0);
        chk("t2_pc", PC, 32'h4);
        check_ir("t2", 1'b1);
        tick();

        // 3: stall three cycles in DELIVER
        start_fetch();
        push_ack(32'h0123_4567);
        Stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_ir("t3_stall", 1'b0);
            chk("t3_instr_hold", Instruction, 32'h0123_4567);
            chk("t3_busy", 32'(Busy), 32'd1);
            tick();
        end
        Stall = 1'b0;
        #1;
        check_ir("t3_go", 1'b1);
        tick();
        check_ir("t3_once", 1'b0);
        chk("t3_idle", 32'(Busy), 32'd0);
        chk("t3_pc", PC, 32'h8);

        // 4: redirect during REQ, last target wins, data discarded
        start_fetch();
        Redirect      = 1'b1;
        Redirect_Addr = 32'h0000_02F0;
        tick();
        Redirect_Addr = 32'h0000_0103;
        tick();
        Redirect = 1'b0;
        chk("t4_pc_hold", PC, 32'h8);
        chk("t4_addr_hold", Mem_Addr, 32'h8);
        chk("t4_req", 32'(Mem_Req), 32'd1);
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'hDEAD_BEEF;
        tick();
        Mem_Ack = 1'b0;
        #1;
        check_ir("t4_discard", 1'b0);
        chk("t4_idle", 32'(Busy), 32'd0);
        chk("t4_pc", PC, 32'h0000_0100);
        start_fetch();
        chk("t4_next_addr", Mem_Addr, 32'h0000_0100);
        push_ack(32'h1111_2222);
        check_ir("t4_next", 1'b1);
        tick();
        chk("t4_next_pc", PC, 32'h0000_0104);

        // Redirect together with Fetch_En in IDLE, then squash in DELIVER
        Fetch_En      = 1'b1;
        Redirect      = 1'b1;
        Redirect_Addr = 32'h0000_0207;
        tick();
        Fetch_En = 1'b0;
        Redirect = 1'b0;
        chk("t4b_addr", Mem_Addr, 32'h0000_0204);
        chk("t4b_pc", PC, 32'h0000_0204);
        push_ack(32'h3333_4444);
        chk("t4b_pc_inc", PC, 32'h0000_0208);
        Redirect      = 1'b1;
        Redirect_Addr = 32'h0000_0031;
        #1;
        check_ir("t4b_squash", 1'b0);
        discard = exp_q.pop_front();
        tick();
        Redirect = 1'b0;
        chk("t4b_squash_pc", PC, 32'h0000_0030);
        chk("t4b_squash_idle", 32'(Busy), 32'd0);

        // 5: PC wrap at the top of the address space
        Redirect      = 1'b1;
        Redirect_Addr = 32'hFFFF_FFFF;
        tick();
        Redirect = 1'b0;
        chk("t5_pc_top", PC, 32'hFFFF_FFFC);
        start_fetch();
        chk("t5_addr", Mem_Addr, 32'hFFFF_FFFC);
        push_ack(32'h5555_AAAA);
        chk("t5_wrap", PC, 32'h0);
        check_ir("t5", 1'b1);
        tick();

        // Reset mid-REQ, then a late ack must be ignored
        start_fetch();
        tick();
        chk("t5_in_req", 32'(Mem_Req), 32'd1);
        Rst_n = 1'b0;
        #1;
        check_reset("t5_async_rst");
        Mem_Ack   = 1'b1;
        Mem_Rdata = 32'h7777_7777;
        tick();
        tick();
        Mem_Ack = 1'b0;
        Rst_n   = 1'b1;
        tick();
        Mem_Ack = 1'b1;
        tick();
        Mem_Ack = 1'b0;
        check_ir("t5_late_ack", 1'b0);
        chk("t5_late_busy", 32'(Busy), 32'd0);
        chk("t5_late_instr", Instruction, 32'h0);
        chk("t5_late_pc", PC, 32'h0);

        // 6: no ack at all
        reqcnt = 0;
        start_fetch();
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 40 && Mem_Req; i++) begin
            reqcnt++;
            tick();
        end
        chk("t6_req_cycles", 32'(reqcnt), 32'd16);
        chk("t6_req_drop", 32'(Mem_Req), 32'd0);
        chk("t6_fault", 32'(Fault), 32'd1);
        chk("t6_pc", PC, 32'h0);
        chk("t6_idle", 32'(Busy), 32'd0);
        tick();
        chk("t6_fault_sticky", 32'(Fault), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            chk("t6_req_hold", 32'(Mem_Req), 32'd1);
            chk("t6_no_fault", 32'(Fault), 32'd0);
            tick();
        end
        push_ack(32'h9999_0000);
        check_ir("t6_late", 1'b1);
        chk("t6_pc", PC, 32'h4);
        tick();
`endif

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
